uart_emu_chan: RTL and testbench

Parametrised, synthesizable successor to the bench UART emulator: a full-duplex UART channel with configurable data width, bit period, stop bits and TX/RX FIFO depth. It drives the chassis board's host-side serial line in simulation and in hardware self-test builds, where the fixed-format behavioural emulator cannot be used. It exposes valid/ready byte streams to the local logic and serial TX/RX pins to the DUT.

---
 rtl/uart_emu_chan.sv | 201 ++++++++++++++++++++
 tb/tb_uart_emu_chan.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_emu_chan.sv
// uart_emu_chan: full-duplex UART channel with first-word-fall-through TX/RX FIFOs and valid/ready streams.
// Define UART_EMU_PARITY_EN to add an even parity bit in both directions.
module uart_emu_chan #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 768,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 Rstn,
  output logic                 TX,
  input  logic                 RX,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_parity_err,
  output logic                 tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]    DATA_END = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_END = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_XOR = {1'b1, {AW{1'b0}}};
`ifdef UART_EMU_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW:0]          r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  state_t               r_tx_st, r_rx_st;
  logic [CW-1:0]        r_tx_cnt, r_rx_cnt;
  logic [3:0]           r_tx_bit, r_rx_bit;
  logic [DATA_BITS-1:0] r_tx_sh, r_rx_sh;
  logic                 r_tx, r_rx_s1, r_rx_s2, r_rx_s3, r_rx_fe, r_rx_ov;
  logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_bit_end;
  logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_bit_end, w_rx_half;
  logic w_rx_stop, w_rx_ok, w_rx_room, w_rx_perr;
  assign w_tx_empty   = r_tx_wp == r_tx_rp;
  assign w_tx_full    = (r_tx_wp ^ r_tx_rp) == FULL_XOR;
  assign w_tx_push    = tx_valid & ~w_tx_full;
  assign w_tx_bit_end = r_tx_cnt == BIT_END;
  // Pop on IDLE or at the end of the last stop bit, so queued characters go out back-to-back
  assign w_tx_pop     = ~w_tx_empty & (r_tx_st == IDLE |
                        (r_tx_st == STOP & w_tx_bit_end & r_tx_bit == STOP_END));
  assign w_rx_empty   = r_rx_wp == r_rx_rp;
  assign w_rx_full    = (r_rx_wp ^ r_rx_rp) == FULL_XOR;
  assign w_rx_pop     = rx_ready & ~w_rx_empty;
  assign w_rx_bit_end = r_rx_cnt == BIT_END;
  assign w_rx_half    = r_rx_cnt == HALF_END;
  assign w_rx_stop    = r_rx_st == STOP & w_rx_bit_end;
  assign w_rx_ok      = r_rx_s2 & ~w_rx_perr;
  assign w_rx_room    = ~w_rx_full | w_rx_pop;
  assign w_rx_push    = w_rx_stop & w_rx_ok & w_rx_room;
  assign TX           = r_tx;
  assign tx_ready     = ~w_tx_full;
  assign tx_busy      = r_tx_st != IDLE | ~w_tx_empty;
  assign rx_data      = r_rx_mem[r_rx_rp[AW-1:0]];
  assign rx_valid     = ~w_rx_empty;
  assign rx_frame_err = r_rx_fe;
  assign rx_overrun   = r_rx_ov;
`ifdef UART_EMU_PARITY_EN
  logic r_tx_par, r_rx_par, r_rx_pe;
  assign w_rx_perr     = ^{r_rx_sh, r_rx_par};
  assign rx_parity_err = r_rx_pe;
  always_ff @(posedge Clk or negedge Rstn)
    if (!Rstn) r_rx_pe <= 1'b0;
    else r_rx_pe <= w_rx_stop & w_rx_perr;
`else
  assign w_rx_perr     = 1'b0;
  assign rx_parity_err = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_sh;
  end
  always_ff @(posedge Clk or negedge Rstn)
    if (!Rstn) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      r_tx_wp <= r_tx_wp + (AW+1)'(w_tx_push);
      r_tx_rp <= r_tx_rp + (AW+1)'(w_tx_pop);
      r_rx_wp <= r_rx_wp + (AW+1)'(w_rx_push);
      r_rx_rp <= r_rx_rp + (AW+1)'(w_rx_pop);
    end
  always_ff @(posedge Clk or negedge Rstn)
    if (!Rstn) begin
      r_tx_st  <= IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx     <= 1'b1;
`ifdef UART_EMU_PARITY_EN
      r_tx_par <= 1'b0;
`endif
    end else begin
      r_tx_cnt <= (r_tx_st == IDLE || w_tx_bit_end) ? '0 : r_tx_cnt + CW'(1);
      if (w_tx_pop) begin
        r_tx_st <= START;
        r_tx    <= 1'b0;
        r_tx_sh <= r_tx_mem[r_tx_rp[AW-1:0]];
`ifdef UART_EMU_PARITY_EN
        r_tx_par <= ^r_tx_mem[r_tx_rp[AW-1:0]];
`endif
      end else if (w_tx_bit_end)
        case (r_tx_st)
          START: begin
            r_tx_st  <= DATA;
            r_tx     <= r_tx_sh[0];
            r_tx_bit <= '0;
          end
          DATA:
            if (r_tx_bit == DATA_END) begin
              r_tx_bit <= '0;
`ifdef UART_EMU_PARITY_EN
              r_tx_st  <= PAR;
              r_tx     <= r_tx_par;
`else
              r_tx_st  <= STOP;
              r_tx     <= 1'b1;
`endif
            end else begin
              r_tx_bit <= r_tx_bit + 4'd1;
              r_tx     <= r_tx_sh[1];
              r_tx_sh  <= r_tx_sh >> 1;
            end
`ifdef UART_EMU_PARITY_EN
          PAR: begin
            r_tx_st  <= STOP;
            r_tx     <= 1'b1;
            r_tx_bit <= '0;
          end
`endif
          STOP:
            if (r_tx_bit == STOP_END) r_tx_st <= IDLE;
            else r_tx_bit <= r_tx_bit + 4'd1;
          default: r_tx_st <= IDLE;
        endcase
    end
  always_ff @(posedge Clk or negedge Rstn)
    if (!Rstn) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
      r_rx_st  <= IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
      r_rx_fe  <= 1'b0;
      r_rx_ov  <= 1'b0;
`ifdef UART_EMU_PARITY_EN
      r_rx_par <= 1'b0;
`endif
    end else begin
      r_rx_s1  <= RX;
      r_rx_s2  <= r_rx_s1;
      r_rx_s3  <= r_rx_s2;
      r_rx_fe  <= w_rx_stop & ~r_rx_s2;
      r_rx_ov  <= w_rx_stop & w_rx_ok & ~w_rx_room;
      r_rx_cnt <= (r_rx_st == IDLE || (r_rx_st == START ? w_rx_half : w_rx_bit_end)) ?
                  '0 : r_rx_cnt + CW'(1);
      case (r_rx_st)
        IDLE: if (r_rx_s3 & ~r_rx_s2) r_rx_st <= START;
        START:
          if (w_rx_half) begin
            r_rx_bit <= '0;
            r_rx_st  <= r_rx_s2 ? IDLE : DATA;
          end
        DATA:
          if (w_rx_bit_end) begin
            r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
            r_rx_bit <= r_rx_bit + 4'd1;
`ifdef UART_EMU_PARITY_EN
            r_rx_st  <= (r_rx_bit == DATA_END) ? PAR : DATA;
`else
            r_rx_st  <= (r_rx_bit == DATA_END) ? STOP : DATA;
`endif
          end
`ifdef UART_EMU_PARITY_EN
        PAR:
          if (w_rx_bit_end) begin
            r_rx_par <= r_rx_s2;
            r_rx_st  <= STOP;
          end
`endif
        STOP: if (w_rx_bit_end) r_rx_st <= IDLE;
        default: r_rx_st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_emu_chan.sv
// tb_uart_emu_chan: directed bench for uart_emu_chan at BAUD_DIV=16, 8 data bits, 1 stop bit, 2-entry FIFOs.
module tb_uart_emu_chan;
  localparam int BD = 16;
`ifdef UART_EMU_PARITY_EN
  localparam int PB = 1;
  logic bad_par = 1'b0;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = BD * (10 + PB);
  logic       Clk = 1'b0, Rstn = 1'b0, rx_drv = 1'b1, loop = 1'b0;
  logic       tx_valid = 1'b0, rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00, rx_data, v;
  logic       RX, TX, tx_ready, rx_valid, rx_frame_err, rx_overrun, rx_parity_err, tx_busy;
  logic [7:0] burst [4] = '{8'h00, 8'hFF, 8'h3C, 8'h81};
  int n_checks = 0, n_err = 0, n_fe = 0, n_ov = 0, n_pe = 0, busy_cyc = 0;

  assign RX = loop ? TX : rx_drv;
  always #5 Clk = ~Clk;

  uart_emu_chan #(.DATA_BITS(8), .BAUD_DIV(BD), .STOP_BITS(1), .FIFO_DEPTH(2)) dut (
    .Clk(Clk), .Rstn(Rstn), .TX(TX), .RX(RX),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .rx_parity_err(rx_parity_err), .tx_busy(tx_busy)
  );

  always @(negedge Clk) begin
    if (rx_frame_err) n_fe++;
    if (rx_overrun) n_ov++;
    if (rx_parity_err) n_pe++;
    if (tx_busy) busy_cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(BD);
    end
`ifdef UART_EMU_PARITY_EN
    rx_drv = ^d ^ bad_par;
    tick(BD);
`endif
    rx_drv = stop;
    tick(BD);
    rx_drv = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    for (int t = 0; t < 2 * FRAME && !tx_ready; t++) tick(1);
    check("push_ready", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    for (int t = 0; t < 2 * FRAME && !rx_valid; t++) tick(1);
    check({tag, "_valid"}, rx_valid, 1);
    check(tag, rx_data, exp);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_tx", TX, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_errs", {rx_frame_err, rx_overrun, rx_parity_err}, 0);
    Rstn = 1'b1;
    tick(2);
    // single character, bit-exact timing
    v = 8'hA5;
    tx_data  = v;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check("tx_lat_1", TX, 1);
    check("tx_busy_fifo", tx_busy, 1);
    tick(1);
    check("tx_start", TX, 0);
    tick(BD - 1);
    check("tx_start_end", TX, 0);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_bit%0d", i), TX, v[i]);
      tick(BD);
    end
`ifdef UART_EMU_PARITY_EN
    check("tx_par", TX, ^v);
    tick(BD);
`endif
    check("tx_stop", TX, 1);
    tick(BD - 1);
    check("tx_busy_last", tx_busy, 1);
    tick(1);
    check("tx_busy_done", tx_busy, 0);
    check("tx_idle", TX, 1);
    // loopback burst, no idle gap between frames
    loop = 1'b1;
    busy_cyc = 0;
    for (int i = 0; i < 4; i++) push(burst[i]);
    for (int i = 0; i < 4; i++) pop($sformatf("loop_rx%0d", i), burst[i]);
    for (int t = 0; t < 2 * FRAME && tx_busy; t++) tick(1);
    check("loop_idle", tx_busy, 0);
    tick(4);
    check("loop_busy_cycles", busy_cyc, 4 * FRAME + 1);
    check("loop_no_errs", n_fe + n_ov + n_pe, 0);
    loop = 1'b0;
    // overrun on a 2-deep RX FIFO
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    tick(4);
    check("ovr_before", n_ov, 0);
    send_rx(8'h33, 1'b1);
    tick(4);
    check("ovr_pulse", n_ov, 1);
    pop("ovr_pop0", 8'h11);
    pop("ovr_pop1", 8'h22);
    tick(1);
    check("ovr_empty", rx_valid, 0);
    // glitch and framing error
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(3 * BD);
    check("glitch_valid", rx_valid, 0);
    check("glitch_fe", n_fe, 0);
    send_rx(8'h5A, 1'b0);
    tick(4);
    check("fe_pulse", n_fe, 1);
    check("fe_valid", rx_valid, 0);
    check("fe_no_ovr", n_ov, 1);
`ifdef UART_EMU_PARITY_EN
    bad_par = 1'b1;
    send_rx(8'h07, 1'b1);
    bad_par = 1'b0;
    tick(4);
    check("par_err_pulse", n_pe, 1);
    check("par_err_valid", rx_valid, 0);
    send_rx(8'h07, 1'b1);
    pop("par_ok", 8'h07);
    check("par_ok_pe", n_pe, 1);
`else
    send_rx(8'h07, 1'b1);
    pop("nopar_rx", 8'h07);
    check("nopar_pe", n_pe, 0);
`endif
    // reset during TX data bits with a character still queued
    push(8'hC3);
    push(8'h55);
    tick(52);
    check("rst_mid_pre_tx", TX, 0);
    check("rst_mid_pre_busy", tx_busy, 1);
    rx_drv = 1'b0;
    #2 Rstn = 1'b0;
    #1;
    check("rst_mid_tx", TX, 1);
    check("rst_mid_ready", tx_ready, 1);
    check("rst_mid_busy", tx_busy, 0);
    check("rst_mid_rx_valid", rx_valid, 0);
    rx_drv = 1'b1;
    tick(2);
    Rstn = 1'b1;
    tick(3 * FRAME);
    check("rst_after_tx", TX, 1);
    check("rst_after_busy", tx_busy, 0);
    check("rst_after_rx_valid", rx_valid, 0);
    check("rst_after_fe", n_fe, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
